pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32 pipeline.
- Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. The ID/EX `clear` input is driven from FlushE.
- Generates EX-stage operand forwarding selects.
- Contains a wait-state FSM that freezes the pipeline while a multi-cycle data-memory access completes, plus saturating performance counters.

Parameters:
- TIMEOUT, 16: maximum WAIT-state cycles before a data-memory access is abandoned; valid range ≥2.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- Rs1D, Rs2D  in  5  source registers of the instruction in ID
- Rs1E, Rs2E, RdE  in  5  sources and destination of the instruction in EX
- RdM, RdW  in  5  destinations in MEM and WB
- RegWriteM, RegWriteW  in  1  register-write enables in MEM and WB
- LoadE  in  1  EX instruction is a load (ResultSrcE==2'b01)
- PCSrcE  in  1  taken branch or jump resolved in EX
- dmem_req  in  1  MEM instruction accesses data memory
- dmem_ready  in  1  data memory completes access this cycle
- ForwardAE, ForwardBE  out  2  00=regfile, 01=WB result, 10=MEM ALU result
- StallF, StallD, StallE, StallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM registers
- FlushD, FlushE, FlushW  out  1  bubble IF-ID / ID-EX / MEM-WB registers
- bus_err  out  1  one-cycle pulse when an access times out
- stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- Reset (async, active-high, clk domain):
  - FSM goes to IDLE; wait_cnt=0; bus_err=0; stall_cnt=0; flush_cnt=0.
  - Combinational outputs evaluate from inputs with state=IDLE.
  - Reset mid-WAIT abandons the access with no bus_err.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise 00. MEM takes priority over WB.
  - ForwardBE is identical using Rs2E.
- Load-use: lwStall = LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- Memory FSM, states IDLE and WAIT:
  - IDLE: dmem_req && !dmem_ready → mem_stall=1, next WAIT, wait_cnt←1.
  - IDLE: dmem_ready, or no request → stay IDLE, no stall (zero-wait access).
  - WAIT: dmem_ready → mem_stall=0, next IDLE, wait_cnt←0.
  - WAIT: !dmem_ready && wait_cnt<TIMEOUT → mem_stall=1, wait_cnt++.
  - WAIT: !dmem_ready && wait_cnt==TIMEOUT → mem_stall=0, bus_err=1 (registered, visible next cycle for one cycle), next IDLE.
  - dmem_req is not rechecked in WAIT; the request is held by StallM.
- Stall and flush equations:
  - StallF = StallD = lwStall | mem_stall.
  - StallE = StallM = mem_stall.
  - FlushW = mem_stall.
  - FlushD = PCSrcE & ~mem_stall.
  - FlushE = (lwStall | PCSrcE) & ~mem_stall.
- Simultaneous events:
  - mem_stall dominates. Branch redirect and load-use bubble are deferred, not lost: EX is frozen, so PCSrcE and lwStall re-present after release.
  - PCSrcE together with lwStall: both FlushD and FlushE assert, and StallF/StallD also assert. The PC register treats PCSrcE as overriding StallF.
- Counters, both saturating at all-ones:
  - stall_cnt increments every cycle StallF=1.
  - flush_cnt increments every cycle FlushE=1.

Test Plan:
- Forward priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 → ForwardAE=10. With RegWriteM=0 → 01. With RdM=RdW=0 and matching Rs1E=0 → 00.
- Load-use: LoadE=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for exactly that cycle. StallE=0. stall_cnt and flush_cnt each +1.
- Multi-cycle access:
  - dmem_req=1, dmem_ready low for 3 cycles then high → StallF..StallM=1 and FlushW=1 for 3 cycles, 0 on the ready cycle.
  - FSM returns to IDLE. stall_cnt=3. bus_err never asserts.
- Timeout: TIMEOUT=4, dmem_ready held 0 → stall for cycles 1..4, released on the 5th cycle. bus_err high exactly one cycle after release.
- Branch during wait: PCSrcE=1 while mem_stall=1 → FlushD=FlushE=0 during the wait. FlushD=FlushE=1 on the cycle dmem_ready=1.
- Async reset mid-WAIT, then saturation:
  - Assert reset between clock edges → outputs immediately reflect IDLE with no bus_err.
  - Preload near saturation (CNT_W=4, 16 stall cycles) → stall_cnt holds 4'hF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline: operand forwarding,
// load-use interlock, multi-cycle data-memory wait FSM and saturating perf counters.
module pipe_hazard_fwd_sel (
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       we_m,
  input  logic       we_w,
  output logic [1:0] fwd
);
  always_comb begin
    fwd = 2'b00;
    if (we_m && rd_m != 5'd0 && rd_m == rs)      fwd = 2'b10;
    else if (we_w && rd_w != 5'd0 && rd_w == rs) fwd = 2'b01;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int NUM_SRC = 2;
  localparam int WCW     = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               state, state_nx;
  logic [WCW-1:0]       wait_cnt, cnt_nx;
  logic                 mem_stall, berr_nx, lw_stall;
  logic [NUM_SRC-1:0][4:0] rs_e;
  logic [NUM_SRC-1:0][1:0] fwd;

  // One forwarding selector per EX source operand
  assign rs_e = {Rs2E, Rs1E};
  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_fwd
      pipe_hazard_fwd_sel u_sel (
        .rs   (rs_e[g]),
        .rd_m (RdM),
        .rd_w (RdW),
        .we_m (RegWriteM),
        .we_w (RegWriteW),
        .fwd  (fwd[g])
      );
    end
  endgenerate
  assign ForwardAE = fwd[0];
  assign ForwardBE = fwd[1];

  assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Request is held by StallM during WAIT, so dmem_req is only sampled in IDLE
  always_comb begin
    state_nx  = state;
    cnt_nx    = wait_cnt;
    mem_stall = 1'b0;
    berr_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (dmem_req && !dmem_ready) begin
          mem_stall = 1'b1;
          state_nx  = S_WAIT;
          cnt_nx    = WCW'(1);
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (wait_cnt < WCW'(TIMEOUT)) begin
          mem_stall = 1'b1;
          cnt_nx    = wait_cnt + WCW'(1);
        end else begin
          berr_nx  = 1'b1;
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= cnt_nx;
      bus_err  <= berr_nx;
    end
  end

  // A memory wait freezes EX, so redirects and bubbles re-present after release
  assign StallF = lw_stall | mem_stall;
  assign StallD = lw_stall | mem_stall;
  assign StallE = mem_stall;
  assign StallM = mem_stall;
  assign FlushW = mem_stall;
  assign FlushD = PCSrcE & ~mem_stall;
  assign FlushE = (lw_stall | PCSrcE) & ~mem_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (FlushE && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule
